// File: rtl/debug_unit_ctrl.sv
// Debug controller: loads a program over UART into instruction memory, then runs or single-steps
// the pipeline and reports the PC back. Single-step is compiled in only when DEBUG_STEP_EN is set.
module debug_unit_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int IMEM_ADDR_WIDTH = 5
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_rx_done,
    input  logic [DATA_WIDTH_UART-1:0] i_rx_data,
    input  logic                       i_tx_done,
    input  logic                       i_halt,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_result,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0]      o_imem_data,
    output logic                       o_cpu_enable
);

    localparam int NUM_BYTES = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0]           LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [IMEM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        StLoad,
        StWrite,
        StWaitCmd,
        StRun,
`ifdef DEBUG_STEP_EN
        StStep,
`endif
        StSend,
        StDone
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             byte_cnt_q, byte_cnt_d;
    logic [IMEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        word_q, word_d;
    logic [DATA_WIDTH-1:0]        pc_q, pc_d;
    logic                         finish_q, finish_d;
    logic                         tx_busy_q, tx_busy_d;
    logic                         tx_signal_q, tx_signal_d;
    logic [DATA_WIDTH_UART-1:0]   tx_result_q, tx_result_d;
    logic                         imem_we;
    logic                         cpu_enable;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StLoad;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            pc_q        <= '0;
            finish_q    <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_signal_q <= 1'b0;
            tx_result_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            pc_q        <= pc_d;
            finish_q    <= finish_d;
            tx_busy_q   <= tx_busy_d;
            tx_signal_q <= tx_signal_d;
            tx_result_q <= tx_result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        word_d      = word_q;
        pc_d        = pc_q;
        finish_d    = finish_q;
        tx_busy_d   = tx_busy_q;
        tx_signal_d = 1'b0;
        tx_result_d = tx_result_q;
        imem_we     = 1'b0;
        cpu_enable  = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (i_rx_done) begin
                    word_d[byte_cnt_q*DATA_WIDTH_UART +: DATA_WIDTH_UART] = i_rx_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = StWrite;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            StWrite: begin
                imem_we = 1'b1;
                if (word_q[DATA_WIDTH-1 -: 6] == 6'b111111 || addr_q == LAST_ADDR) begin
                    state_d = StWaitCmd;
                end else begin
                    addr_d  = addr_q + IMEM_ADDR_WIDTH'(1);
                    state_d = StLoad;
                    // A byte landing during the write strobe starts the next word.
                    if (i_rx_done) begin
                        word_d                        = '0;
                        word_d[DATA_WIDTH_UART-1:0]   = i_rx_data;
                        byte_cnt_d                    = CNT_W'(1);
                    end
                end
            end
            StWaitCmd: begin
                if (i_rx_done) begin
                    if (i_rx_data == '0) begin
                        state_d = StRun;
                    end
`ifdef DEBUG_STEP_EN
                    else if (i_rx_data == DATA_WIDTH_UART'(1)) begin
                        state_d = StStep;
                    end
`endif
                end
            end
            StRun: begin
                cpu_enable = 1'b1;
                if (i_halt) begin
                    state_d    = StSend;
                    pc_d       = i_pc;
                    finish_d   = 1'b1;
                    byte_cnt_d = '0;
                    tx_busy_d  = 1'b0;
                end
            end
`ifdef DEBUG_STEP_EN
            StStep: begin
                cpu_enable = 1'b1;
                state_d    = StSend;
                pc_d       = i_pc;
                finish_d   = i_halt;
                byte_cnt_d = '0;
                tx_busy_d  = 1'b0;
            end
`endif
            StSend: begin
                if (!tx_busy_q) begin
                    tx_signal_d = 1'b1;
                    tx_result_d = pc_q[byte_cnt_q*DATA_WIDTH_UART +: DATA_WIDTH_UART];
                    tx_busy_d   = 1'b1;
                end else if (i_tx_done) begin
                    tx_busy_d = 1'b0;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = finish_q ? StDone : StWaitCmd;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    assign o_tx_signal  = tx_signal_q;
    assign o_tx_result  = tx_result_q;
    assign o_imem_we    = imem_we;
    assign o_imem_addr  = addr_q;
    assign o_imem_data  = word_q;
    assign o_cpu_enable = cpu_enable;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Randomized self-checking bench for debug_unit_ctrl; expectations come from a word-list /
// byte-stream model of the load, run, step and report behaviour.
module tb_debug_unit_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic        i_tx_done;
    logic        i_halt;
    logic [31:0] i_pc;
    logic        o_tx_signal;
    logic [7:0]  o_tx_result;
    logic        o_imem_we;
    logic [4:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_cpu_enable;

    debug_unit_ctrl #(
        .DATA_WIDTH      (32),
        .DATA_WIDTH_UART (8),
        .IMEM_ADDR_WIDTH (5)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_tx_done    (i_tx_done),
        .i_halt       (i_halt),
        .i_pc         (i_pc),
        .o_tx_signal  (o_tx_signal),
        .o_tx_result  (o_tx_result),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_cpu_enable (o_cpu_enable)
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observed activity, sampled on the falling edge.
    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  tx_q[$];
    int          en_cnt    = 0;
    int          tx_glitch = 0;
    logic        tx_wait   = 1'b0;
    logic [7:0]  tx_held   = '0;
    logic        hold_tx   = 1'b0;

    initial begin
        forever begin
            @(negedge i_clock);
            if (!i_reset) begin
                if (o_imem_we) begin
                    wr_addr.push_back(o_imem_addr);
                    wr_data.push_back(o_imem_data);
                end
                if (o_cpu_enable) en_cnt++;
                if (tx_wait && o_tx_result !== tx_held) tx_glitch++;
                if (tx_wait && i_tx_done) tx_wait = 1'b0;
                if (o_tx_signal) begin
                    tx_q.push_back(o_tx_result);
                    tx_held = o_tx_result;
                    tx_wait = 1'b1;
                end
            end
        end
    end

    // UART transmitter model: acknowledges each byte after a random delay unless held off.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clock);
            if (o_tx_signal && !i_reset) begin
                int d;
                d = $urandom_range(1, 6);
                repeat (d) @(posedge i_clock);
                while (hold_tx) @(posedge i_clock);
                #1 i_tx_done = 1'b1;
                @(posedge i_clock);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_rx_done = 1'b1;
        i_rx_data = b;
        tick();
        i_rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        tx_q.delete();
        en_cnt    = 0;
        tx_glitch = 0;
        tx_wait   = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_we"}, 32'(o_imem_we), 0);
        check_eq({tag, "_addr"}, 32'(o_imem_addr), 0);
        check_eq({tag, "_data"}, o_imem_data, 0);
        check_eq({tag, "_txsig"}, 32'(o_tx_signal), 0);
        check_eq({tag, "_txres"}, 32'(o_tx_result), 0);
        check_eq({tag, "_en"}, 32'(o_cpu_enable), 0);
    endtask

    // Reset asserted off the clock edge so the outputs must clear asynchronously.
    task automatic apply_reset(input string tag);
        i_reset = 1'b1;
        #1;
        check_reset_outs(tag);
        tick();
        i_reset   = 1'b0;
        i_rx_done = 1'b0;
        i_halt    = 1'b0;
        hold_tx   = 1'b0;
        repeat (10) tick();
        clear_obs();
    endtask

    function automatic logic is_halt(input logic [31:0] w);
        return w[31:26] == 6'h3f;
    endfunction

    function automatic logic [31:0] rand_plain();
        logic [31:0] w;
        w = $urandom;
        if (is_halt(w)) w[26] = 1'b0;
        return w;
    endfunction

    // Memory image expected: words up to and including the first halt, capped at 32 entries.
    task automatic load_and_check(input string tag, input logic [31:0] words[$], input int maxgap);
        logic [31:0] exp[$];
        logic        stop;
        stop = 1'b0;
        foreach (words[i]) begin
            if (!stop && exp.size() < 32) begin
                exp.push_back(words[i]);
                if (is_halt(words[i])) stop = 1'b1;
            end
        end
        wr_addr.delete();
        wr_data.delete();
        foreach (words[i]) send_word(words[i], maxgap);
        repeat (4) tick();
        check_eq({tag, "_nwr"}, wr_data.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wr_data.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), i);
            check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], exp[i]);
        end
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq("tx_count", tx_q.size(), n);
    endtask

    task automatic check_tx_bytes(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("%s_tx%0d", tag, i), (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hxxxx_xxxx,
                     32'(pc[8*i +: 8]));
        check_eq({tag, "_txstable"}, tx_glitch, 0);
    endtask

    // Halt is raised during the n-th enabled cycle, so exactly n enable cycles are expected.
    task automatic do_run(input int n, input logic [31:0] pc);
        i_pc = pc;
        send_byte(8'h00, 0);
        repeat (n - 1) tick();
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int n, input logic [31:0] pc);
        int e0;
        tx_q.delete();
        e0 = en_cnt;
        do_run(n, pc);
        wait_tx(4, 300);
        check_eq({tag, "_encycles"}, en_cnt - e0, n);
        check_tx_bytes(tag, pc);
    endtask

    task automatic check_done(input string tag);
        int e0;
        int w0;
        e0 = en_cnt;
        w0 = wr_data.size();
        send_byte(8'h00, 2);
        send_byte(8'h01, 2);
        send_word(32'h1234_5678, 1);
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        repeat (30) tick();
        check_eq({tag, "_en"}, en_cnt - e0, 0);
        check_eq({tag, "_tx"}, tx_q.size(), 4);
        check_eq({tag, "_wr"}, wr_data.size(), w0);
    endtask

    task automatic step_and_check(input string tag, input logic [31:0] pc);
        int e0;
        tx_q.delete();
        e0   = en_cnt;
        i_pc = pc;
        send_byte(8'h01, 0);
`ifdef DEBUG_STEP_EN
        wait_tx(4, 300);
        check_eq({tag, "_encycles"}, en_cnt - e0, 1);
        check_tx_bytes(tag, pc);
`else
        repeat (40) tick();
        check_eq({tag, "_encycles"}, en_cnt - e0, 0);
        check_eq({tag, "_ntx"}, tx_q.size(), 0);
`endif
    endtask

    initial begin
        logic [31:0] words[$];
        logic [31:0] pc;
        int          n;

        i_reset   = 1'b1;
        i_rx_done = 1'b0;
        i_rx_data = '0;
        i_halt    = 1'b0;
        i_pc      = '0;
        repeat (2) @(posedge i_clock);
        #1;
        check_reset_outs("por");
        i_reset = 1'b0;
        repeat (3) tick();
        clear_obs();

        // Three-word program ending on a halt word, junk command, then run to halt.
        words = '{32'h2043_0005, 32'h0000_0000, 32'hFC00_0000};
        load_and_check("load3", words, 2);
        send_byte(8'h55, 3);
        run_and_check("run50", 50, 32'h0000_0074);
        check_done("done1");

        // Reset mid-word discards the partial word.
        apply_reset("rst_done");
        send_byte(8'h22, 1);
        send_byte(8'h22, 1);
        apply_reset("rst_midload");
        words = '{32'h1111_2222, 32'hFC00_0001};
        load_and_check("partial", words, 1);
        step_and_check("step4", 32'h0000_0004);
        step_and_check("step8", 32'h0000_0008);

        // UART acknowledgement withheld: a single pulse and a frozen byte.
        hold_tx = 1'b1;
        tx_q.delete();
        pc = 32'hA1B2_C3D4;
        do_run(7, pc);
        repeat (1000) tick();
        check_eq("hold_npulse", tx_q.size(), 1);
        check_eq("hold_byte", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hxxxx_xxxx, 32'h0000_00D4);
        check_eq("hold_stable", tx_glitch, 0);
        hold_tx = 1'b0;
        wait_tx(4, 300);
        check_tx_bytes("hold", pc);

        // Reset in the middle of a send.
        apply_reset("rst_pre_send");
        words = '{32'hFC00_0000};
        load_and_check("onehalt", words, 0);
        hold_tx = 1'b1;
        do_run(3, 32'h0000_00FF);
        repeat (20) tick();
        apply_reset("rst_midsend");

        // Full memory: 32 plain words, then extra bytes that are not commands.
        words.delete();
        for (int i = 0; i < 32; i++) words.push_back(rand_plain());
        load_and_check("full", words, 2);
        send_word(32'hC333_A55A, 1);
        repeat (4) tick();
        check_eq("full_extra_nwr", wr_data.size(), 32);
        run_and_check("fullrun", $urandom_range(1, 40), $urandom);
        check_done("done_full");

        // Random programs, random steps and runs.
        for (int t = 0; t < 4; t++) begin
            apply_reset($sformatf("rst_rand%0d", t));
            words.delete();
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) words.push_back(rand_plain());
            pc = $urandom;
            pc[31:26] = 6'h3f;
            words.push_back(pc);
            load_and_check($sformatf("rload%0d", t), words, 3);
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) step_and_check($sformatf("rstep%0d_%0d", t, i), $urandom);
            run_and_check($sformatf("rrun%0d", t), $urandom_range(1, 60), $urandom);
            check_done($sformatf("rdone%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debug_unit_ctrl.md
DEBUG_UNIT_CTRL -- requirements
Module: debug_unit_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction/PC word width.
REQ-002 SHALL have parameter DATA_WIDTH_UART, default 8: UART byte width.
REQ-003 SHALL have parameter IMEM_ADDR_WIDTH, default 5: instruction-memory word address width (32 words).
REQ-004 SHALL have port i_clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_rx_done  in  1  one-cycle pulse, UART byte received.
REQ-007 SHALL have port i_rx_data  in  DATA_WIDTH_UART  received byte, valid with i_rx_done.
REQ-008 SHALL have port i_tx_done  in  1  one-cycle pulse, UART finished sending a byte.
REQ-009 SHALL have port i_halt  in  1  pipeline reached halt instruction (opcode 6'b111111) in WB.
REQ-010 SHALL have port i_pc  in  DATA_WIDTH  current pipeline PC.
REQ-011 SHALL have port o_tx_signal  out  1  one-cycle pulse, start UART transmit.
REQ-012 SHALL have port o_tx_result  out  DATA_WIDTH_UART  byte to transmit, stable from pulse until i_tx_done.
REQ-013 SHALL have port o_imem_we  out  1  instruction-memory write strobe.
REQ-014 SHALL have port o_imem_addr  out  IMEM_ADDR_WIDTH  write word address.
REQ-015 SHALL have port o_imem_data  out  DATA_WIDTH  write data.
REQ-016 SHALL have port o_cpu_enable  out  1  pipeline clock enable.

Function
REQ-017 SHALL implement states LOAD, WRITE, WAIT_CMD, RUN, STEP, SEND, DONE.
REQ-018 LOAD: each i_rx_done byte SHALL be assembled little-endian (first byte -> [7:0], fourth -> [31:24]); byte counter 0..3.
REQ-019 On fourth byte SHALL enter WRITE: o_imem_we=1 for exactly one cycle, o_imem_addr=current address, o_imem_data=assembled word; byte counter cleared.
REQ-020 After WRITE: if word[31:26]==6'b111111 SHALL go WAIT_CMD; else if address==2^IMEM_ADDR_WIDTH-1 SHALL go WAIT_CMD (memory full, no wrap); else address+1, back to LOAD.
REQ-021 i_rx_done arriving in WRITE SHALL be accepted as byte 0 of the next word (no byte lost).
REQ-022 WAIT_CMD: received byte 8'h00 SHALL go RUN; 8'h01 SHALL go STEP (see REQ-031); any other byte ignored, stay WAIT_CMD.
REQ-023 RUN: o_cpu_enable=1 every cycle until i_halt sampled high, then o_cpu_enable=0 next cycle and go SEND.
REQ-024 STEP: o_cpu_enable=1 for exactly one cycle, then go SEND.
REQ-025 SEND: SHALL latch i_pc on entry and transmit 4 bytes little-endian; one o_tx_signal pulse per byte; next pulse only after i_tx_done for previous byte.
REQ-026 After SEND: if entry came from RUN, or i_halt was high at latch, SHALL go DONE; else WAIT_CMD.
REQ-027 DONE: terminal; o_cpu_enable=0, no writes, no transmits, rx ignored, until reset.
REQ-028 i_rx_done outside LOAD/WRITE/WAIT_CMD SHALL be ignored; i_halt outside RUN/STEP/SEND ignored.
REQ-029 o_cpu_enable SHALL be 0 in all states except RUN and the single STEP cycle.

Reset
REQ-030 i_reset high SHALL immediately force LOAD, address 0, byte counter 0, partial word discarded; o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_tx_signal=0, o_tx_result=0, o_cpu_enable=0; applies mid-load, mid-run and mid-send (pending UART byte abandoned).

Configuration
REQ-031 Macro DEBUG_STEP_EN defined: STEP state and command 8'h01 SHALL be compiled in; undefined: STEP removed, 8'h01 ignored like any unknown command.

Verification
REQ-032 Load 3 words 0x2043_0005, 0x0000_0000 (4 bytes each), then 0xFC00_0000 -> three o_imem_we pulses, addr 0,1,2, data exact; state WAIT_CMD after third.
REQ-033 Load 32 non-halt words -> 32 writes addr 0..31, then WAIT_CMD; 33rd word's bytes ignored until command.
REQ-034 After load send 8'h00, hold i_pc=0x0000_0074, assert i_halt after 50 cycles -> o_cpu_enable high exactly 50 cycles, TX bytes 0x74,0x00,0x00,0x00, then DONE.
REQ-035 With DEBUG_STEP_EN, send 8'h01 twice, i_pc=0x4 then 0x8 -> o_cpu_enable exactly one cycle each, TX 0x04,0,0,0 then 0x08,0,0,0, state WAIT_CMD; without macro -> no enable, no TX.
REQ-036 Assert i_reset after 2 bytes of a word, then load full word 0x1111_2222 -> single write addr 0, data 0x1111_2222.
REQ-037 Withhold i_tx_done 1000 cycles during SEND -> only one o_tx_signal pulse, o_tx_result stable throughout.
